// File: rtl/countdown_timer_pkg.sv
// Shared types for the loadable countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle done pulse on expiry.
// Define COUNTDOWN_TIMER_AUTORELOAD_EN to restart from the last load value (periodic ticks).
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic             done_q;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_valid) begin
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload_q <= load_value;
`endif
            if (load_value != '0) begin
              count_q <= load_value;
              state_q <= pause ? HOLD : RUN;
            end else begin
              // A zero load expires immediately without leaving IDLE.
              count_q <= '0;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (pause) begin
            state_q <= HOLD;
          end else if (count_q == WIDTH'(1)) begin
            done_q <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            count_q <= reload_q;
`else
            count_q <= '0;
            state_q <= IDLE;
`endif
          end else begin
            count_q <= count_q - WIDTH'(1);
          end
        end
        HOLD: begin
          // Resuming edge only returns to RUN; the next decrement is one cycle later.
          if (!pause) state_q <= RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign count      = count_q;
  assign done       = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer (one-shot and auto-reload builds).
module tb_countdown_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_value = '0;
  logic             load_ready;
  logic             pause = 1'b0;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  int checks   = 0;
  int failures = 0;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_value (load_value),
    .load_ready (load_ready),
    .pause      (pause),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int c, input bit d, input bit b, input bit r);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".done"},  32'(done),  32'(d));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".ready"}, 32'(load_ready), 32'(r));
  endtask

  initial begin
    // Reset held for two cycles
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 1);
    rst = 1'b0;

    // Zero load expires at once and stays idle
    load_valid = 1'b1; load_value = 8'd0;
    tick();
    chk_all("load0", 0, 1, 0, 1);
    load_valid = 1'b0;
    tick();
    chk_all("load0_after", 0, 0, 0, 1);

    // Pause is ignored while idle
    pause = 1'b1;
    tick();
    chk_all("idle_pause", 0, 0, 0, 1);
    pause = 1'b0;

`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
    // Load 5, plain run
    load_valid = 1'b1; load_value = 8'd5;
    tick();
    load_valid = 1'b0;
    chk_all("l5_load", 5, 0, 1, 0);
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk_all($sformatf("l5_c%0d", i), i, (i == 0), (i != 0), (i == 0));
    end
    tick();
    chk_all("l5_idle", 0, 0, 0, 1);

    // Load 3, one paused edge at count 2, with an ignored load offered meanwhile
    load_valid = 1'b1; load_value = 8'd3;
    tick();
    chk_all("p3_load", 3, 0, 1, 0);
    load_valid = 1'b0;
    tick();
    chk_all("p3_c2", 2, 0, 1, 0);
    pause = 1'b1; load_valid = 1'b1; load_value = 8'd9;
    tick();
    chk_all("p3_hold", 2, 0, 1, 0);
    pause = 1'b0;
    tick();
    chk_all("p3_resume", 2, 0, 1, 0);
    load_valid = 1'b0;
    tick();
    chk_all("p3_c1", 1, 0, 1, 0);
    tick();
    chk_all("p3_done", 0, 1, 0, 1);

    // Back-to-back: load 1 in the done cycle, then load 2 in the next done cycle
    load_valid = 1'b1; load_value = 8'd1;
    tick();
    chk_all("b1_load", 1, 0, 1, 0);
    load_value = 8'd2;
    tick();
    chk_all("b1_done", 0, 1, 0, 1);
    tick();
    chk_all("b2_load", 2, 0, 1, 0);
    load_valid = 1'b0;
    tick();
    chk_all("b2_c1", 1, 0, 1, 0);
    tick();
    chk_all("b2_done", 0, 1, 0, 1);

    // Load while pause high goes straight to HOLD
    load_valid = 1'b1; load_value = 8'd2; pause = 1'b1;
    tick();
    load_valid = 1'b0;
    chk_all("lh_load", 2, 0, 1, 0);
    tick();
    chk_all("lh_hold", 2, 0, 1, 0);
    pause = 1'b0;
    tick();
    chk_all("lh_resume", 2, 0, 1, 0);
    tick();
    chk_all("lh_c1", 1, 0, 1, 0);
    tick();
    chk_all("lh_done", 0, 1, 0, 1);

    // Reset mid-count aborts without a done pulse
    load_valid = 1'b1; load_value = 8'd4;
    tick();
    load_valid = 1'b0;
    chk_all("r4_load", 4, 0, 1, 0);
    tick();
    tick();
    chk_all("r4_c2", 2, 0, 1, 0);
    rst = 1'b1;
    tick();
    chk_all("r4_rst", 0, 0, 0, 1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all($sformatf("r4_post%0d", i), 0, 0, 0, 1);
    end
`else
    // Auto-reload: load 3 gives done every third cycle, never reading 0
    load_valid = 1'b1; load_value = 8'd3;
    tick();
    load_valid = 1'b0;
    chk_all("ar_load", 3, 0, 1, 0);
    for (int i = 0; i < 7; i++) begin
      int exp_c;
      exp_c = 2 - (i % 3);
      if (exp_c == 0) exp_c = 3;
      tick();
      chk_all($sformatf("ar_%0d", i), exp_c, (exp_c == 3), 1, 0);
    end
    // Pause freezes the count while auto-reloading; loads stay refused
    pause = 1'b1; load_valid = 1'b1; load_value = 8'd7;
    tick();
    chk_all("ar_hold", 2, 0, 1, 0);
    pause = 1'b0; load_valid = 1'b0;
    tick();
    chk_all("ar_resume", 2, 0, 1, 0);
    tick();
    chk_all("ar_c1", 1, 0, 1, 0);
    tick();
    chk_all("ar_reload", 3, 1, 1, 0);
    rst = 1'b1;
    tick();
    chk_all("ar_rst", 0, 0, 0, 1);
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
